// File: rtl/hc_stream_xor.sv
// hc_stream_xor: keystream prefetch FIFO and valid/ready XOR stage behind the HC stream cipher core
//   clk, reset_n                      : clock, synchronous active-low reset
//   start                             : pulse to re-init the core and flush all local state
//   core_init, core_next              : one-cycle init / keystream-word requests to the core
//   core_ready, core_s, core_s_valid  : core idle level, keystream word and its strobe
//   din_data/valid/ready              : input word handshake
//   dout_data/valid/ready             : output word (din ^ keystream) handshake
//   word_count, busy                  : words output since start, high while initialising
module hc_stream_xor #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        core_init,
    output logic        core_next,
    input  logic        core_ready,
    input  logic [31:0] core_s,
    input  logic        core_s_valid,
    input  logic [31:0] din_data,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] word_count,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;

    state_t        r_state;
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          r_pending;
    logic          r_core_init;
    logic          r_core_next;
    logic          r_dout_valid;
    logic [31:0]   r_dout_data;
    logic [31:0]   r_word_count;
    logic          r_busy;
    logic          w_push;
    logic          w_pop;

    // Only a word we actually asked for is captured; stale or spurious strobes are dropped.
    assign w_push    = core_s_valid && r_pending;
    assign din_ready = (r_state == ST_RUN) && (r_cnt != '0) && (!r_dout_valid || dout_ready);
    assign w_pop     = din_valid && din_ready;

    assign core_init  = r_core_init;
    assign core_next  = r_core_next;
    assign dout_data  = r_dout_data;
    assign dout_valid = r_dout_valid;
    assign word_count = r_word_count;
    assign busy       = r_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_wr         <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_core_init  <= 1'b0;
            r_core_next  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
            r_word_count <= '0;
            r_busy       <= 1'b0;
        end else if (start) begin
            r_state      <= ST_INIT;
            r_wr         <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_core_init  <= 1'b1;
            r_core_next  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_word_count <= '0;
            r_busy       <= 1'b1;
        end else begin
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
            // core_ready still reflects the pre-init core while core_init is high.
            if (r_state == ST_INIT && !r_core_init && core_ready) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
            end
            // One outstanding request at most, so a free slot is guaranteed for its word.
            if (w_push) begin
                r_pending <= 1'b0;
            end else if (r_state == ST_RUN && !r_pending && core_ready && r_cnt < DEPTH_W) begin
                r_core_next <= 1'b1;
                r_pending   <= 1'b1;
            end
            if (w_push) begin
                r_fifo[r_wr] <= core_s;
                r_wr         <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd         <= r_rd + 1'b1;
                r_dout_data  <= din_data ^ r_fifo[r_rd];
                r_dout_valid <= 1'b1;
                r_word_count <= r_word_count + 32'd1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: doc/hc_stream_xor.md
Name: hc_stream_xor

Overview:
- Keystream consumer stage placed directly downstream of the HC stream cipher core.
- Issues init and next requests to the core and prefetches 32-bit keystream words into a small FIFO.
- XORs them with incoming data words, using valid/ready handshakes on both the data input and the data output.
- Gives the cipher core a flow-controlled streaming interface for encrypt/decrypt (the same operation).

Parameters:
FIFO_DEPTH, 4, keystream prefetch FIFO depth in words; power of two, legal range 2..16.

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse: (re)initialise core with current key/IV, flush state
core_init  output  1  one-cycle init pulse to cipher core
core_next  output  1  one-cycle request for one keystream word
core_ready  input  1  level; core idle and able to accept next
core_s  input  32  keystream word from core
core_s_valid  input  1  one-cycle strobe; core_s valid this cycle
din_data  input  32  plaintext/ciphertext word
din_valid  input  1  din_data valid
din_ready  output  1  block accepts din this cycle
dout_data  output  32  din_data XOR keystream word
dout_valid  output  1  dout_data valid
dout_ready  input  1  downstream accepts dout
word_count  output  32  words processed since last start
busy  output  1  high in INIT state

Behaviour:
- Reset (reset_n=0 at clk edge) puts the block in IDLE with the FIFO empty and pending=0. All outputs are 0: core_init, core_next, din_ready, dout_valid, dout_data, word_count, busy.
- Reset dominates start and all other inputs in the same cycle.
- FSM states: IDLE, INIT, RUN.
- IDLE:
  - din_ready=0 and no core_next is issued.
  - start -> core_init=1 for exactly one cycle, go to INIT.
- INIT:
  - busy=1.
  - core_ready is ignored in the cycle in which core_init is high.
  - From the next cycle on, core_ready=1 -> RUN.
- Any state, start=1:
  - core_init pulses; FIFO flushed; pending cleared; dout_valid cleared; word_count=0; state INIT.
  - start has priority over all data handshakes in that cycle.
- Prefetch, in RUN only:
  - Condition: pending=0, core_ready=1, fifo_count<FIFO_DEPTH.
  - Action: core_next=1 for one cycle and pending<=1.
  - At most one request is outstanding, so the FIFO can never overflow.
- Keystream capture:
  - core_s_valid with pending=1 -> push core_s at the FIFO tail, pending<=0.
  - A new core_next may issue in the cycle after the push.
  - core_s_valid with pending=0 (for example a stale word after start) is ignored.
- Data path:
  - din_ready = (state==RUN) && fifo_count>0 && (!dout_valid || dout_ready). It is combinational from registered state and dout_ready.
  - On a din handshake (din_valid && din_ready), at the next edge: dout_data <= din_data ^ FIFO head, pop the FIFO, dout_valid<=1, word_count<=word_count+1.
  - dout_valid && dout_ready with no new din handshake -> dout_valid<=0.
- Latency:
  - din to dout is 1 cycle.
  - Throughput is 1 word/cycle while the FIFO is non-empty.
  - Sustained throughput is limited by the core's next-to-s_valid latency.
- Output hold: while dout_valid && !dout_ready, dout_data and dout_valid are held stable and din_ready=0.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - fifo_count has log2(FIFO_DEPTH)+1 bits.
  - A simultaneous push and pop leaves the count unchanged and both pointers advance.
  - Empty: din_ready=0.
  - Full: no core_next is issued.
- word_count wraps 0xFFFFFFFF -> 0 with no flag.
- dout_data keeps its last value when dout_valid=0; it is cleared only by reset.

Test Plan:
1. Reset, then start; core model with core_ready=1 after 3 cycles and s_valid 2 cycles after each next, keystream 0x11111111,0x22222222,...; hold din_valid=0 -> exactly 4 core_next pulses, FIFO full, then no further core_next.
2. From scenario 1, send din 0xAAAAAAAA, 0xBBBBBBBB back-to-back with dout_ready=1 -> dout 0xBBBBBBBB, 0x99999999 on consecutive cycles, one cycle after each handshake; word_count=2.
3. Hold dout_ready=0 with dout_valid=1 for 5 cycles -> dout_data stable, din_ready=0, no FIFO pop; releasing dout_ready resumes 1 word/cycle.
4. Assert start in RUN with a request pending and 2 words buffered -> dout_valid=0, word_count=0, state INIT; the stale s_valid arriving 1 cycle later is ignored and the FIFO is still empty on entering RUN.
5. Stream 2^32+3 words with word_count preloaded near wrap (force) -> count reads 0xFFFFFFFF then 0x00000000; data integrity unaffected.
6. Spurious core_s_valid while pending=0 in RUN -> FIFO count unchanged; start and reset_n=0 in the same cycle -> IDLE with all outputs 0 and no core_init pulse.
